dram_bank_sel_decoder: RTL and testbench



---
 rtl/dram_bank_sel_decoder_if.sv | 32 +++
 rtl/dram_bank_sel_decoder.sv | 133 +++++++++++++
 tb/tb_dram_bank_sel_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dram_bank_sel_decoder_if.sv
// Handshake bundle for dram_bank_sel_decoder.
//   master : command scheduler side (drives request, accepts select)
//   slave  : decoder side
// Signals:
//   in_valid/in_ready/in_addr      request handshake and bank address
//   out_valid/out_ready            registered select handshake
//   out_onehot/out_addr            one-hot and binary bank select
//   busy                           per-bank busy flags
interface dram_bank_sel_decoder_if #(
   parameter int unsigned ADDR_W = 3
);
   localparam int unsigned NUM_OUT = 2 ** ADDR_W;

   logic               in_valid;
   logic               in_ready;
   logic [ADDR_W-1:0]  in_addr;
   logic               out_valid;
   logic               out_ready;
   logic [NUM_OUT-1:0] out_onehot;
   logic [ADDR_W-1:0]  out_addr;
   logic [NUM_OUT-1:0] busy;

   modport master (
      output in_valid, in_addr, out_ready,
      input  in_ready, out_valid, out_onehot, out_addr, busy
   );

   modport slave (
      input  in_valid, in_addr, out_ready,
      output in_ready, out_valid, out_onehot, out_addr, busy
   );
endinterface

// File: rtl/dram_bank_sel_decoder.sv
// Registered N-to-2^N one-hot bank-select decoder with per-bank busy timers.
// A request is accepted on in_valid && in_ready; the one-hot select appears one
// cycle later and the selected bank is held busy for BUSY_CYC cycles, during
// which further requests to that bank are stalled.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous, active-high reset
//   bus         dram_bank_sel_decoder_if.slave (request/select handshakes, busy)
//   accept_cnt  saturating count of accepted requests (only when the
//               DRAM_DEC_ACCEPT_CNT_EN macro is defined)
//
// Parameters:
//   ADDR_W    bank address width; NUM_OUT = 2**ADDR_W outputs
//   BUSY_CYC  busy cycles after selection (0 = no blocking)
//   BUSY_W    timer width, BUSY_CYC must be < 2**BUSY_W
//
// Optional feature macro: DRAM_DEC_ACCEPT_CNT_EN
module dram_bank_sel_decoder #(
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned BUSY_CYC = 4,
   parameter int unsigned BUSY_W   = 3
) (
   input logic                     clk,
   input logic                     rst,
   dram_bank_sel_decoder_if.slave  bus
`ifdef DRAM_DEC_ACCEPT_CNT_EN
   ,
   output logic [15:0]             accept_cnt
`endif
);

   localparam int unsigned NUM_OUT = 2 ** ADDR_W;

   logic                out_valid_q, out_valid_d;
   logic [NUM_OUT-1:0]  out_onehot_q, out_onehot_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [BUSY_W-1:0]   timer_q [NUM_OUT];
   logic [BUSY_W-1:0]   timer_d [NUM_OUT];
   logic [NUM_OUT-1:0]  busy_w;
   logic                in_ready_w;
   logic                accept;

   always_comb begin
      for (int i = 0; i < NUM_OUT; i++) begin
         busy_w[i] = (timer_q[i] != '0);
      end
   end

   // Deliberately independent of in_valid so the scheduler may look before it leaps.
   always_comb begin
      in_ready_w = !rst && (!out_valid_q || bus.out_ready) && !busy_w[bus.in_addr];
   end

   // Gating with in_valid keeps an undriven in_addr out of the state.
   always_comb begin
      accept = bus.in_valid && in_ready_w;
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_onehot_d = out_onehot_q;
      out_addr_d   = out_addr_q;
      if (accept) begin
         // Also covers simultaneous drain + accept: overwrite, no bubble.
         out_valid_d  = 1'b1;
         out_onehot_d = NUM_OUT'(1) << bus.in_addr;
         out_addr_d   = bus.in_addr;
      end else if (out_valid_q && bus.out_ready) begin
         // out_addr keeps its last value after a drain.
         out_valid_d  = 1'b0;
         out_onehot_d = '0;
      end
   end

   // Load has priority over decrement on the same bank.
   always_comb begin
      for (int i = 0; i < NUM_OUT; i++) begin
         timer_d[i] = timer_q[i];
         if (accept && (bus.in_addr == ADDR_W'(i))) begin
            timer_d[i] = BUSY_W'(BUSY_CYC);
         end else if (timer_q[i] != '0) begin
            timer_d[i] = timer_q[i] - BUSY_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_onehot_q <= '0;
         out_addr_q   <= '0;
         for (int i = 0; i < NUM_OUT; i++) begin
            timer_q[i] <= '0;
         end
      end else begin
         out_valid_q  <= out_valid_d;
         out_onehot_q <= out_onehot_d;
         out_addr_q   <= out_addr_d;
         for (int i = 0; i < NUM_OUT; i++) begin
            timer_q[i] <= timer_d[i];
         end
      end
   end

`ifdef DRAM_DEC_ACCEPT_CNT_EN
   logic [15:0] accept_cnt_q, accept_cnt_d;

   always_comb begin
      accept_cnt_d = accept_cnt_q;
      if (accept && (accept_cnt_q != 16'hFFFF)) begin
         accept_cnt_d = accept_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         accept_cnt_q <= '0;
      end else begin
         accept_cnt_q <= accept_cnt_d;
      end
   end

   assign accept_cnt = accept_cnt_q;
`endif

   assign bus.in_ready   = in_ready_w;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_onehot = out_onehot_q;
   assign bus.out_addr   = out_addr_q;
   assign bus.busy       = busy_w;

endmodule

// File: tb/tb_dram_bank_sel_decoder.sv
// Self-checking bench for dram_bank_sel_decoder: directed steps followed by
// randomized traffic, all compared against a cycle-level model of the bank
// rules (countdown of busy cycles per bank, one pending select slot).
module tb_dram_bank_sel_decoder;

`ifdef DRAM_DEC_ACCEPT_CNT_EN
   localparam int BC = 0;
`else
   localparam int BC = 4;
`endif

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;
   int   n_fail;

   dram_bank_sel_decoder_if #(.ADDR_W(3)) bus ();

`ifdef DRAM_DEC_ACCEPT_CNT_EN
   logic [15:0] accept_cnt;
`endif

   dram_bank_sel_decoder #(
      .ADDR_W   (3),
      .BUSY_CYC (BC),
      .BUSY_W   (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave)
`ifdef DRAM_DEC_ACCEPT_CNT_EN
      ,
      .accept_cnt (accept_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   int m_left [8];
   bit m_valid;
   int m_addr;
   int m_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic acc, input int a, input logic ordy);
      if (r) begin
         for (int i = 0; i < 8; i++) m_left[i] = 0;
         m_valid = 0;
         m_addr  = 0;
         m_cnt   = 0;
      end else begin
         for (int i = 0; i < 8; i++) if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
         if (acc) begin
            m_left[a] = BC;
            m_valid   = 1;
            m_addr    = a;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
         end else if (m_valid && ordy) begin
            m_valid = 0;
         end
      end
   endtask

   task automatic check_outputs();
      logic [7:0] e_onehot;
      logic [7:0] e_busy;
      e_onehot = m_valid ? (8'h01 << m_addr) : 8'h00;
      for (int i = 0; i < 8; i++) e_busy[i] = (m_left[i] > 0);
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("out_onehot", 64'(bus.out_onehot), 64'(e_onehot));
      check("out_addr", 64'(bus.out_addr), 64'(m_addr));
      check("busy", 64'(bus.busy), 64'(e_busy));
`ifdef DRAM_DEC_ACCEPT_CNT_EN
      check("accept_cnt", 64'(accept_cnt), 64'(m_cnt));
`endif
   endtask

   // One clock cycle: drive, check in_ready, clock, update model, check outputs.
   task automatic step(input logic r, input logic v, input logic [2:0] a, input logic ordy,
                       output logic acc);
      logic exp_rdy;
      rst           = r;
      bus.in_valid  = v;
      bus.in_addr   = a;
      bus.out_ready = ordy;
      #1;
      exp_rdy = !r && (!m_valid || ordy) && (m_left[a] == 0);
      check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      model_edge(r, v && exp_rdy, int'(a), ordy);
      #1;
      check_outputs();
   endtask

   initial begin
      logic acc;
      int   cnt;
      int   gap;
      int   exp_gap;
      logic [7:0] held;
      n_total = 0;
      n_pass  = 0;
      n_fail  = 0;
      for (int i = 0; i < 8; i++) m_left[i] = 0;
      m_valid = 0;
      m_addr  = 0;
      m_cnt   = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_addr   = 3'd0;
      bus.out_ready = 1'b1;

      // 1. Reset then idle.
      step(1'b1, 1'b0, 3'd0, 1'b1, acc);
      step(1'b1, 1'b0, 3'd0, 1'b1, acc);
      step(1'b0, 1'b0, 3'd0, 1'b1, acc);
      check("idle_valid", 64'(bus.out_valid), 64'd0);
      check("idle_onehot", 64'(bus.out_onehot), 64'h00);
      check("idle_busy", 64'(bus.busy), 64'h00);
      check("idle_ready", 64'(bus.in_ready), 64'd1);

      // 2. Single request to bank 5; busy[5] lasts exactly BC cycles.
      step(1'b0, 1'b1, 3'd5, 1'b1, acc);
      check("single_acc", 64'(acc), 64'd1);
      check("single_onehot", 64'(bus.out_onehot), 64'h20);
      check("single_addr", 64'(bus.out_addr), 64'd5);
      cnt = (bus.busy[5] === 1'b1) ? 1 : 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 3'd0, 1'b1, acc);
         if (bus.busy[5] === 1'b1) cnt++;
      end
      check("single_busy_len", 64'(cnt), 64'(BC));

      // 3. Same-bank stall with an interleaved request to bank 6.
      step(1'b0, 1'b1, 3'd2, 1'b1, acc);
      check("stall_first_acc", 64'(acc), 64'd1);
      step(1'b0, 1'b1, 3'd6, 1'b1, acc);
      check("stall_other_bank", 64'(acc), 64'd1);
      gap = 1;
      acc = 1'b0;
      while (!acc && gap < 20) begin
         step(1'b0, 1'b1, 3'd2, 1'b1, acc);
         gap++;
      end
      exp_gap = (BC + 1 > 2) ? BC + 1 : 2;
      check("stall_gap", 64'(gap), 64'(exp_gap));
      step(1'b0, 1'b0, 3'd0, 1'b1, acc);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 3'd0, 1'b1, acc);

      // 4. Backpressure then simultaneous drain + accept.
      step(1'b0, 1'b1, 3'd0, 1'b0, acc);
      check("bp_first_acc", 64'(acc), 64'd1);
      held = bus.out_onehot;
      check("bp_onehot", 64'(held), 64'h01);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 3'd7, 1'b0, acc);
         check("bp_no_acc", 64'(acc), 64'd0);
         check("bp_stable", 64'(bus.out_onehot), 64'h01);
      end
      step(1'b0, 1'b1, 3'd7, 1'b1, acc);
      check("bp_drain_acc", 64'(acc), 64'd1);
      check("bp_no_bubble_valid", 64'(bus.out_valid), 64'd1);
      check("bp_no_bubble_onehot", 64'(bus.out_onehot), 64'h80);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 3'd0, 1'b1, acc);

      // 5. Reset mid-operation.
      step(1'b0, 1'b1, 3'd4, 1'b0, acc);
      check("mid_busy", 64'(bus.busy), (BC > 0) ? 64'h10 : 64'h00);
      step(1'b1, 1'b1, 3'd4, 1'b0, acc);
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_onehot", 64'(bus.out_onehot), 64'h00);
      check("mid_rst_addr", 64'(bus.out_addr), 64'd0);
      check("mid_rst_busy", 64'(bus.busy), 64'h00);
      step(1'b0, 1'b1, 3'd4, 1'b1, acc);
      check("mid_reaccept", 64'(acc), 64'd1);
      check("mid_reaccept_onehot", 64'(bus.out_onehot), 64'h10);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [2:0] a;
         a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
         step(($urandom_range(0, 49) == 0), 1'($urandom), a, ($urandom_range(0, 3) != 0), acc);
      end

`ifdef DRAM_DEC_ACCEPT_CNT_EN
      // 6. Accept counter: rotating banks, then saturation.
      step(1'b1, 1'b0, 3'd0, 1'b1, acc);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 3'(i % 8), 1'b1, acc);
      check("cnt_ten", 64'(accept_cnt), 64'd10);
      for (int i = 0; i < 65530; i++) step(1'b0, 1'b1, 3'(i % 8), 1'b1, acc);
      check("cnt_saturate", 64'(accept_cnt), 64'hFFFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
